memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: ROUND_ROBIN, 1, tie policy (1 = alternate grants, 0 = data port always wins).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset; asserting it forces every state element to its reset value immediately.
REQ-004 i_req_valid  in  1 / i_req_addr  in  32  fetch-port read request.
REQ-005 i_req_ready  out  1  fetch request accepted this cycle.
REQ-006 i_rsp_valid  out  1 / i_rsp_data  out  32  fetch response.
REQ-007 d_req_valid  in  1 / d_req_cmd  in  1 (controller_pkg READ/WRITE) / d_req_addr  in  32 / d_req_wdata  in  32 / d_req_mask  in  32  data-port request.
REQ-008 d_req_ready  out  1  data request accepted this cycle.
REQ-009 d_rsp_valid  out  1 / d_rsp_data  out  32  data response; write acknowledge.
REQ-010 memory_ready  in  1 / memory_valid  in  1 / read_memory_data  in  32  memory side.
REQ-011 read_memory_address, write_memory_address, write_memory_data, write_memory_mask  out  32 each / memory_command  out  1 / memory_enable  out  1  memory side.

Function
REQ-012 States: IDLE (nothing outstanding), WAIT (one access outstanding); at most one access is outstanding at any time.
REQ-013 Issue is permitted when memory_ready=1 and (state=IDLE or (state=WAIT and memory_valid=1)).
REQ-014 On a permitted issue with at least one req_valid, exactly one port is granted: its req_ready=1 and memory_enable=1 in that same cycle, combinationally; the other port's req_ready=0.
REQ-015 Only one valid: that port is granted. Both valid: ROUND_ROBIN=1 grants the port not granted last; ROUND_ROBIN=0 grants the data port.
REQ-016 The granted address drives both read_memory_address and write_memory_address.
REQ-017 Fetch grant: memory_command=READ, write_memory_data=0, write_memory_mask=0.
REQ-018 Data grant: memory_command=d_req_cmd, write_memory_data=d_req_wdata, write_memory_mask=d_req_mask.
REQ-019 Without a grant: memory_enable=0, both req_ready=0, memory-side data/address/mask outputs=0, memory_command=READ.
REQ-020 On issue, the owner (I/D) and command are registered and the state goes to WAIT; the grant is recorded as last-granted.
REQ-021 In WAIT with memory_valid=1: owner's rsp_valid=1 for exactly that cycle; rsp_data=read_memory_data for READ, 0 for WRITE; the other port's rsp_valid=0.
REQ-022 In WAIT with memory_valid=1 and no new issue, the state returns to IDLE; with a new issue (REQ-013), it stays in WAIT with the new owner, giving one access per cycle.
REQ-023 rsp_valid/rsp_data are combinational from memory_valid and the registered owner; minimum request-to-response latency is 1 cycle.
REQ-024 memory_valid in IDLE is ignored: no rsp_valid.
REQ-025 memory_ready=0 blocks issue in any state; it does not block completion of an outstanding access.
REQ-026 In WAIT without memory_valid, no grant occurs regardless of requests; the access stays outstanding indefinitely.

Reset
REQ-027 reset=0 gives state=IDLE, last-granted=fetch (first tie goes to data), owner=fetch, and command=READ.
REQ-028 During reset all outputs are 0: memory_enable, req_ready, rsp_valid, rsp_data, and memory-side outputs.
REQ-029 Reset mid-access discards the outstanding access; a memory_valid arriving after reset release produces no response.

Verification
REQ-030 Fetch only: i_req_valid=1, addr 0x80000000, memory returns 0x00000013 next cycle -> i_req_ready=1 at cycle N, memory_enable=1, read_memory_address=0x80000000; i_rsp_valid=1, i_rsp_data=0x00000013 at N+1.
REQ-031 Both valid continuously, ROUND_ROBIN=1, memory always valid next cycle -> grants D,I,D,I on consecutive cycles; each rsp routed to the matching port one cycle later.
REQ-032 Data write: cmd=WRITE, addr 0x80001004, wdata 0xDEADBEEF, mask 0x0000FFFF -> memory_command=WRITE, write_memory_mask=0x0000FFFF; next cycle d_rsp_valid=1, d_rsp_data=0.
REQ-033 memory_ready=0 for 3 cycles with both requests valid -> no req_ready and no memory_enable; the first grant occurs in the cycle memory_ready returns to 1.
REQ-034 reset asserted in WAIT, released, then a stray memory_valid=1 -> i_rsp_valid=d_rsp_valid=0; the next tie grants the data port.
REQ-035 ROUND_ROBIN=0, both valid for 4 cycles -> data port granted every cycle; fetch never granted.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates a fetch port and a data port onto a single
// memory interface that allows one outstanding access at a time.
// Ports:
//   clk, reset (async, active-low)
//   fetch port : i_req_valid/addr -> i_req_ready ; i_rsp_valid/data
//   data port  : d_req_valid/cmd/addr/wdata/mask -> d_req_ready ;
//                d_rsp_valid/data (write acknowledge carries zero data)
//   memory side: memory_ready/valid, read_memory_data in ;
//                read/write_memory_address, write_memory_data/mask,
//                memory_command, memory_enable out
module memory_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    input  logic        d_req_cmd,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    input  logic [31:0] d_req_mask,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic [31:0] read_memory_data,
    output logic [31:0] read_memory_address,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_mask,
    output logic        memory_command,
    output logic        memory_enable
);

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e state, state_n;
    logic   last_d, last_d_n;
    logic   owner_d, owner_d_n;
    logic   cmd_q, cmd_q_n;
    logic   done, can_issue, pick_d;

    // All combinational outputs are qualified by reset so that they read
    // zero the instant reset asserts, not just after the next edge.
    assign done      = reset && (state == WAIT) && memory_valid;
    assign can_issue = reset && memory_ready &&
                       ((state == IDLE) || memory_valid);

    // Data wins when it is alone, when ties favour data, or when the
    // fetch port was granted last.
    assign pick_d = d_req_valid &&
                    (!i_req_valid || (ROUND_ROBIN == 1'b0) || !last_d);

    always_comb begin
        state_n              = state;
        last_d_n             = last_d;
        owner_d_n            = owner_d;
        cmd_q_n              = cmd_q;
        i_req_ready          = 1'b0;
        d_req_ready          = 1'b0;
        i_rsp_valid          = 1'b0;
        d_rsp_valid          = 1'b0;
        i_rsp_data           = 32'h0;
        d_rsp_data           = 32'h0;
        read_memory_address  = 32'h0;
        write_memory_address = 32'h0;
        write_memory_data    = 32'h0;
        write_memory_mask    = 32'h0;
        memory_command       = READ;
        memory_enable        = 1'b0;

        if (done) begin
            state_n = IDLE;
            if (owner_d) begin
                d_rsp_valid = 1'b1;
                d_rsp_data  = (cmd_q == WRITE) ? 32'h0 : read_memory_data;
            end else begin
                i_rsp_valid = 1'b1;
                i_rsp_data  = (cmd_q == WRITE) ? 32'h0 : read_memory_data;
            end
        end

        // A new issue in the completion cycle overrides the return to IDLE.
        if (can_issue && pick_d) begin
            d_req_ready          = 1'b1;
            memory_enable        = 1'b1;
            read_memory_address  = d_req_addr;
            write_memory_address = d_req_addr;
            write_memory_data    = d_req_wdata;
            write_memory_mask    = d_req_mask;
            memory_command       = d_req_cmd;
            state_n              = WAIT;
            owner_d_n            = 1'b1;
            cmd_q_n              = d_req_cmd;
            last_d_n             = 1'b1;
        end else if (can_issue && i_req_valid) begin
            i_req_ready          = 1'b1;
            memory_enable        = 1'b1;
            read_memory_address  = i_req_addr;
            write_memory_address = i_req_addr;
            state_n              = WAIT;
            owner_d_n            = 1'b0;
            cmd_q_n              = READ;
            last_d_n             = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            owner_d <= 1'b0;
            cmd_q   <= READ;
        end else begin
            state   <= state_n;
            last_d  <= last_d_n;
            owner_d <= owner_d_n;
            cmd_q   <= cmd_q_n;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with a queue-based scoreboard for
// memory_arbiter (round-robin instance plus a data-priority instance).
module tb_memory_arbiter;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [31:0] I_A = 32'h0000_2000;
    localparam logic [31:0] D_A = 32'h0000_1000;
    localparam logic [31:0] I_B = 32'h0000_3000;
    localparam logic [31:0] D_B = 32'h0000_4000;
    localparam logic [31:0] W   = 32'h0000_0055;
    localparam logic [31:0] M   = 32'h0000_000F;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        d_req_valid;
    logic        d_req_cmd;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [31:0] d_req_mask;
    logic        memory_ready;
    logic        memory_valid;
    logic [31:0] read_memory_data;

    logic        i_req_ready, d_req_ready;
    logic        i_rsp_valid, d_rsp_valid;
    logic [31:0] i_rsp_data, d_rsp_data;
    logic [31:0] read_memory_address, write_memory_address;
    logic [31:0] write_memory_data, write_memory_mask;
    logic        memory_command, memory_enable;

    logic        b_i_req_ready, b_d_req_ready;
    logic        b_i_rsp_valid, b_d_rsp_valid;
    logic [31:0] b_i_rsp_data, b_d_rsp_data;
    logic [31:0] b_read_memory_address, b_write_memory_address;
    logic [31:0] b_write_memory_data, b_write_memory_mask;
    logic        b_memory_command, b_memory_enable;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic chk2 = 1'b0;

    // kind: 0 fetch grant, 1 data grant, 2 fetch rsp, 3 data rsp
    typedef struct {
        int          c;
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        logic [31:0] data;
        logic        cmd;
    } exp_t;

    exp_t q1[$];
    int   q2[$];

    memory_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_mask(d_req_mask), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .memory_ready(memory_ready), .memory_valid(memory_valid),
        .read_memory_data(read_memory_data),
        .read_memory_address(read_memory_address),
        .write_memory_address(write_memory_address),
        .write_memory_data(write_memory_data),
        .write_memory_mask(write_memory_mask),
        .memory_command(memory_command),
        .memory_enable(memory_enable)
    );

    memory_arbiter #(.ROUND_ROBIN(1'b0)) dut_fixed (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .i_req_ready(b_i_req_ready),
        .i_rsp_valid(b_i_rsp_valid), .i_rsp_data(b_i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_mask(d_req_mask), .d_req_ready(b_d_req_ready),
        .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
        .memory_ready(memory_ready), .memory_valid(memory_valid),
        .read_memory_data(read_memory_data),
        .read_memory_address(b_read_memory_address),
        .write_memory_address(b_write_memory_address),
        .write_memory_data(b_write_memory_data),
        .write_memory_mask(b_write_memory_mask),
        .memory_command(b_memory_command),
        .memory_enable(b_memory_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void eg(int kind, logic [31:0] addr, logic cmd,
                               logic [31:0] wdata, logic [31:0] mask);
        exp_t e;
        e.c = cyc; e.kind = kind; e.addr = addr; e.cmd = cmd;
        e.wdata = wdata; e.mask = mask; e.data = 32'h0;
        q1.push_back(e);
    endfunction

    function automatic void er(int kind, logic [31:0] data);
        exp_t e;
        e.c = cyc; e.kind = kind; e.addr = 32'h0; e.cmd = READ;
        e.wdata = 32'h0; e.mask = 32'h0; e.data = data;
        q1.push_back(e);
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ia,
                         input logic dv, input logic dc,
                         input logic [31:0] da, input logic [31:0] dw,
                         input logic [31:0] dm, input logic mr,
                         input logic mv, input logic [31:0] rd);
        i_req_valid      = iv;
        i_req_addr       = ia;
        d_req_valid      = dv;
        d_req_cmd        = dc;
        d_req_addr       = da;
        d_req_wdata      = dw;
        d_req_mask       = dm;
        memory_ready     = mr;
        memory_valid     = mv;
        read_memory_data = rd;
    endtask

    task automatic idle_in(input logic mr, input logic mv,
                           input logic [31:0] rd);
        drive(1'b0, 32'h0, 1'b0, READ, 32'h0, 32'h0, 32'h0, mr, mv, rd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        logic [228:0] all;
        all = {i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid,
               i_rsp_data, d_rsp_data, read_memory_address,
               write_memory_address, write_memory_data,
               write_memory_mask, memory_command, memory_enable};
        checks++;
        if (all != '0) begin
            errors++;
            $display("FAIL %s outputs got %h required 0", name, all);
        end
    endtask

    // Monitor for the round-robin instance.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        logic ok;
        while (q1.size() > 0 && q1[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing event kind=%0d cyc=%0d got nothing",
                     q1[0].kind, q1[0].c);
            void'(q1.pop_front());
        end
        if (i_rsp_valid || d_rsp_valid) begin
            checks++;
            k = d_rsp_valid ? 3 : 2;
            if (q1.size() == 0 || q1[0].c != cyc || q1[0].kind != k) begin
                errors++;
                $display("FAIL rsp cyc=%0d got unexpected kind=%0d required none",
                         cyc, k);
            end else begin
                e  = q1.pop_front();
                ok = (i_rsp_valid != d_rsp_valid) &&
                     ((k == 2) ? (i_rsp_data == e.data)
                               : (d_rsp_data == e.data));
                if (!ok) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d got iv=%0b dv=%0b id=%h dd=%h required kind=%0d data=%h",
                             cyc, i_rsp_valid, d_rsp_valid, i_rsp_data,
                             d_rsp_data, k, e.data);
                end
            end
        end
        if (i_req_ready || d_req_ready) begin
            checks++;
            k = d_req_ready ? 1 : 0;
            if (q1.size() == 0 || q1[0].c != cyc || q1[0].kind != k) begin
                errors++;
                $display("FAIL grant cyc=%0d got unexpected kind=%0d required none",
                         cyc, k);
            end else begin
                e  = q1.pop_front();
                ok = (i_req_ready != d_req_ready) && memory_enable &&
                     (read_memory_address == e.addr) &&
                     (write_memory_address == e.addr) &&
                     (memory_command == e.cmd) &&
                     (write_memory_data == e.wdata) &&
                     (write_memory_mask == e.mask);
                if (!ok) begin
                    errors++;
                    $display("FAIL grant cyc=%0d got ir=%0b dr=%0b en=%0b ra=%h wa=%h cmd=%0b wd=%h wm=%h required kind=%0d a=%h cmd=%0b wd=%h wm=%h",
                             cyc, i_req_ready, d_req_ready, memory_enable,
                             read_memory_address, write_memory_address,
                             memory_command, write_memory_data,
                             write_memory_mask, k, e.addr, e.cmd,
                             e.wdata, e.mask);
                end
            end
        end else begin
            checks++;
            if (memory_enable || memory_command != READ ||
                read_memory_address != 0 || write_memory_address != 0 ||
                write_memory_data != 0 || write_memory_mask != 0) begin
                errors++;
                $display("FAIL no_grant cyc=%0d got en=%0b cmd=%0b ra=%h wa=%h wd=%h wm=%h required all 0",
                         cyc, memory_enable, memory_command,
                         read_memory_address, write_memory_address,
                         write_memory_data, write_memory_mask);
            end
        end
    end

    // Monitor for the data-priority instance.
    always @(negedge clk) begin
        if (chk2) begin
            while (q2.size() > 0 && q2[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL fixed_missing cyc=%0d got no data grant", q2[0]);
                void'(q2.pop_front());
            end
            if (b_i_req_ready || b_d_req_ready) begin
                checks++;
                if (b_i_req_ready || !b_memory_enable ||
                    q2.size() == 0 || q2[0] != cyc) begin
                    errors++;
                    $display("FAIL fixed_grant cyc=%0d got ir=%0b dr=%0b en=%0b required data grant",
                             cyc, b_i_req_ready, b_d_req_ready,
                             b_memory_enable);
                end else begin
                    void'(q2.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        drive(1'b1, 32'h8000_0000, 1'b1, WRITE, 32'h10, 32'h11, 32'h12,
              1'b1, 1'b1, 32'h99);
        #2;
        check_zero("in_reset");
        tick();
        reset = 1'b1;
        idle_in(1'b0, 1'b0, 32'h0);
        tick();

        // Round-robin on ties: D first, then alternate.
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b0, 32'h0);
        eg(1, D_A, READ, W, M);
        tick();
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b1, 32'hA1);
        er(3, 32'hA1); eg(0, I_A, READ, 32'h0, 32'h0);
        tick();
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b1, 32'hA2);
        er(2, 32'hA2); eg(1, D_A, READ, W, M);
        tick();
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b1, 32'hA3);
        er(3, 32'hA3); eg(0, I_A, READ, 32'h0, 32'h0);
        tick();
        idle_in(1'b1, 1'b1, 32'hA4);
        er(2, 32'hA4);
        tick();

        // Fetch only.
        drive(1'b1, 32'h8000_0000, 1'b0, READ, 32'h0, 32'h0, 32'h0,
              1'b1, 1'b0, 32'h0);
        eg(0, 32'h8000_0000, READ, 32'h0, 32'h0);
        tick();
        idle_in(1'b1, 1'b1, 32'h0000_0013);
        er(2, 32'h0000_0013);
        tick();

        // Data write, acknowledged with zero data.
        drive(1'b0, 32'h0, 1'b1, WRITE, 32'h8000_1004, 32'hDEAD_BEEF,
              32'h0000_FFFF, 1'b1, 1'b0, 32'h0);
        eg(1, 32'h8000_1004, WRITE, 32'hDEAD_BEEF, 32'h0000_FFFF);
        tick();
        idle_in(1'b1, 1'b1, 32'hCAFE_F00D);
        er(3, 32'h0);
        tick();

        // memory_ready low blocks issue; last grant was data.
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, I_B, 1'b1, READ, D_B, W, M, 1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, I_B, 1'b1, READ, D_B, W, M, 1'b1, 1'b0, 32'h0);
        eg(0, I_B, READ, 32'h0, 32'h0);
        tick();
        // Completion is not blocked by memory_ready low.
        idle_in(1'b0, 1'b1, 32'hB1);
        er(2, 32'hB1);
        tick();

        // Stray memory_valid in IDLE.
        idle_in(1'b1, 1'b1, 32'h77);
        tick();

        // WAIT without memory_valid holds off new grants.
        drive(1'b1, I_B, 1'b1, READ, D_B, W, M, 1'b1, 1'b0, 32'h0);
        eg(1, D_B, READ, W, M);
        tick();
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, I_B, 1'b1, READ, D_B, W, M, 1'b1, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, I_B, 1'b1, READ, D_B, W, M, 1'b1, 1'b1, 32'hC1);
        er(3, 32'hC1); eg(0, I_B, READ, 32'h0, 32'h0);
        tick();
        idle_in(1'b1, 1'b1, 32'hC2);
        er(2, 32'hC2);
        tick();

        // Reset mid-access.
        drive(1'b1, I_A, 1'b0, READ, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        eg(0, I_A, READ, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_zero("reset_mid_access");
        tick();
        reset = 1'b1;
        idle_in(1'b1, 1'b1, 32'h55);
        tick();
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b0, 32'h0);
        eg(1, D_A, READ, W, M);
        tick();
        idle_in(1'b1, 1'b1, 32'h66);
        er(3, 32'h66);
        tick();

        // Both instances from reset, both ports valid for 4 cycles.
        reset = 1'b0;
        idle_in(1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk2 = 1'b1;
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b0, 32'h0);
        eg(1, D_A, READ, W, M); q2.push_back(cyc);
        tick();
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b1, 32'hE1);
        er(3, 32'hE1); eg(0, I_A, READ, 32'h0, 32'h0); q2.push_back(cyc);
        tick();
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b1, 32'hE2);
        er(2, 32'hE2); eg(1, D_A, READ, W, M); q2.push_back(cyc);
        tick();
        drive(1'b1, I_A, 1'b1, READ, D_A, W, M, 1'b1, 1'b1, 32'hE3);
        er(3, 32'hE3); eg(0, I_A, READ, 32'h0, 32'h0); q2.push_back(cyc);
        tick();
        idle_in(1'b1, 1'b1, 32'hE4);
        er(2, 32'hE4);
        tick();
        chk2 = 1'b0;
        idle_in(1'b1, 1'b0, 32'h0);
        tick();
        tick();

        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL leftover got q1=%0d q2=%0d required 0",
                     q1.size(), q2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
